// File: rtl/cl_sparse_pair_scheduler.sv
// Matched-pair scheduler: walks W & A of one cluster mask pair, LSB first,
// emitting bit position plus dense W/A offsets; last beat carries block counts.
module cl_sparse_pair_scheduler #(
  parameter int BITMASK_LENGTH = 16,
  parameter int INDEX_BITWIDTH = 5
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      ivalid,
  output logic                      oready,
  input  logic [BITMASK_LENGTH-1:0] bitmaskW,
  input  logic [BITMASK_LENGTH-1:0] bitmaskA,
  output logic                      ovalid,
  input  logic                      iready,
  output logic [INDEX_BITWIDTH-1:0] opairPosition,
  output logic [INDEX_BITWIDTH-1:0] opairWIndex,
  output logic [INDEX_BITWIDTH-1:0] opairAIndex,
  output logic                      olast,
  output logic                      oempty,
  output logic [INDEX_BITWIDTH-1:0] onumW,
  output logic [INDEX_BITWIDTH-1:0] onumA
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e state_q, state_d;

  logic [BITMASK_LENGTH-1:0] w_q, a_q, rem_q;
  logic                      ovalid_q, olast_q, oempty_q;
  logic [INDEX_BITWIDTH-1:0] pos_q, widx_q, aidx_q, numw_q, numa_q;

  logic accept, done, load;

  logic [BITMASK_LENGTH-1:0] src_w, src_a, m, rem_nx;
  logic [INDEX_BITWIDTH-1:0] p, wi, ai, nw, na;
  logic                      found;

  assign done   = ovalid_q & iready & olast_q;
  assign accept = ivalid & oready;
  assign load   = accept | (ovalid_q & iready & ~olast_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EMIT;
      EMIT:    if (done && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oready = resetn & ((state_q == IDLE) | done);
  end

  // Beat source: fresh masks on accept, otherwise the remaining walk.
  always_comb begin
    src_w  = accept ? bitmaskW : w_q;
    src_a  = accept ? bitmaskA : a_q;
    m      = accept ? (bitmaskW & bitmaskA) : rem_q;
    rem_nx = m & (m - 1'b1);
    found  = 1'b0;
    p      = '0;
    wi     = '0;
    ai     = '0;
    nw     = '0;
    na     = '0;
    for (int i = 0; i < BITMASK_LENGTH; i++) begin
      nw = nw + INDEX_BITWIDTH'(src_w[i]);
      na = na + INDEX_BITWIDTH'(src_a[i]);
      if (!found) begin
        if (m[i]) begin
          found = 1'b1;
          p     = INDEX_BITWIDTH'(i);
        end else begin
          wi = wi + INDEX_BITWIDTH'(src_w[i]);
          ai = ai + INDEX_BITWIDTH'(src_a[i]);
        end
      end
    end
    if (!found) begin
      wi = '0;
      ai = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      w_q      <= '0;
      a_q      <= '0;
      rem_q    <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      oempty_q <= 1'b0;
      pos_q    <= '0;
      widx_q   <= '0;
      aidx_q   <= '0;
      numw_q   <= '0;
      numa_q   <= '0;
    end else if (load) begin
      w_q      <= src_w;
      a_q      <= src_a;
      rem_q    <= rem_nx;
      ovalid_q <= 1'b1;
      olast_q  <= (rem_nx == '0);
      oempty_q <= (m == '0);
      pos_q    <= p;
      widx_q   <= wi;
      aidx_q   <= ai;
      numw_q   <= (rem_nx == '0) ? nw : '0;
      numa_q   <= (rem_nx == '0) ? na : '0;
    end else if (ovalid_q && iready) begin
      ovalid_q <= 1'b0;
    end
  end

  assign ovalid        = ovalid_q;
  assign olast         = olast_q;
  assign oempty        = oempty_q;
  assign opairPosition = pos_q;
  assign opairWIndex   = widx_q;
  assign opairAIndex   = aidx_q;
  assign onumW         = numw_q;
  assign onumA         = numa_q;

endmodule

// File: tb/tb_cl_sparse_pair_scheduler.sv
// Bench for cl_sparse_pair_scheduler: directed cases plus random traffic
// against a queue of expected beats built from mask arithmetic.
module tb_cl_sparse_pair_scheduler;

  localparam int BL = 16;
  localparam int IW = 5;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          ivalid = 1'b0;
  logic          oready;
  logic [BL-1:0] bitmaskW = '0;
  logic [BL-1:0] bitmaskA = '0;
  logic          ovalid;
  logic          iready = 1'b0;
  logic [IW-1:0] opairPosition, opairWIndex, opairAIndex;
  logic          olast, oempty;
  logic [IW-1:0] onumW, onumA;

  cl_sparse_pair_scheduler #(
    .BITMASK_LENGTH(BL),
    .INDEX_BITWIDTH(IW)
  ) dut (
    .clock(clock), .resetn(resetn),
    .ivalid(ivalid), .oready(oready),
    .bitmaskW(bitmaskW), .bitmaskA(bitmaskA),
    .ovalid(ovalid), .iready(iready),
    .opairPosition(opairPosition),
    .opairWIndex(opairWIndex),
    .opairAIndex(opairAIndex),
    .olast(olast), .oempty(oempty),
    .onumW(onumW), .onumA(onumA)
  );

  always #5 clock = ~clock;

  typedef logic [26:0] beat_t;

  beat_t q[$];
  beat_t held;
  logic  was_stalled = 1'b0;
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic beat_t mk(int pos, int wi, int ai, bit last,
                               bit emp, int nw, int na);
    return {IW'(pos), IW'(wi), IW'(ai), last, emp, IW'(nw), IW'(na)};
  endfunction

  task automatic push_pair(input logic [BL-1:0] w, input logic [BL-1:0] a);
    logic [BL-1:0] m, low;
    int nw, na;
    bit last;
    m  = w & a;
    nw = $countones(w);
    na = $countones(a);
    if (m == '0) begin
      q.push_back(mk(0, 0, 0, 1, 1, nw, na));
    end else begin
      for (int p = 0; p < BL; p++) begin
        if (m[p]) begin
          low  = (BL'(1) << p) - 1'b1;
          last = ((m >> p) >> 1) == '0;
          q.push_back(mk(p, $countones(w & low), $countones(a & low),
                         last, 0, last ? nw : 0, last ? na : 0));
        end
      end
    end
  endtask

  function automatic beat_t cur();
    return {opairPosition, opairWIndex, opairAIndex, olast, oempty,
            onumW, onumA};
  endfunction

  task automatic cycle(input bit iv, input logic [BL-1:0] w,
                       input logic [BL-1:0] a, input bit ir);
    bit exp_rdy;
    @(negedge clock);
    ivalid   = iv;
    bitmaskW = w;
    bitmaskA = a;
    iready   = ir;
    #1;
    chk("ovalid", ovalid, q.size() != 0);
    exp_rdy = (q.size() == 0) || (q.size() == 1 && ir);
    chk("oready", oready, exp_rdy);
    if (was_stalled && ovalid) chk("hold", cur(), held);
    if (ovalid && ir) begin
      if (q.size() == 0) chk("extra_beat", 1, 0);
      else chk("beat", cur(), q.pop_front());
    end
    was_stalled = ovalid && !ir;
    held = cur();
    if (iv && oready) push_pair(w, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(0, '0, '0, 1);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    logic [BL-1:0] w, a;
    #2;
    chk("rst_ovalid", ovalid, 0);
    chk("rst_oready", oready, 0);
    chk("rst_outs", cur(), '0);
    @(negedge clock);
    resetn = 1'b1;

    cycle(1, 16'h00FF, 16'h0F0F, 1);
    drain();
    cycle(1, 16'hA5A5, 16'h5A5A, 1);
    drain();
    cycle(1, 16'hFFFF, 16'h8001, 1);
    drain();

    // Stall after beat 2 with input masks churning
    cycle(1, 16'h00FF, 16'h0F0F, 1);
    cycle(0, 16'h1234, 16'hFFFF, 1);
    cycle(0, '0, '0, 0);
    cycle(0, 16'hFFFF, 16'hFFFF, 0);
    cycle(0, '0, '0, 0);
    drain();

    // Back-to-back pairs
    cycle(1, 16'h0003, 16'h0003, 1);
    cycle(1, 16'h0101, 16'h0100, 1);
    cycle(1, 16'hF000, 16'h3000, 1);
    cycle(1, 16'h0000, 16'hFFFF, 1);
    drain();

    // Reset mid-stream
    cycle(1, 16'h00FF, 16'h0F0F, 1);
    cycle(0, '0, '0, 1);
    @(negedge clock);
    resetn = 1'b0;
    ivalid = 1'b0;
    #1;
    chk("mid_rst_ovalid", ovalid, 0);
    chk("mid_rst_oready", oready, 0);
    chk("mid_rst_outs", cur(), '0);
    q.delete();
    was_stalled = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    cycle(1, 16'h0001, 16'h0001, 1);
    drain();

    for (int i = 0; i < 600; i++) begin
      w = BL'($urandom);
      a = BL'($urandom);
      if ($urandom_range(0, 2) == 0) w = w & BL'($urandom);
      if ($urandom_range(0, 2) == 0) a = a | BL'($urandom);
      cycle($urandom_range(0, 9) < 7, w, a, $urandom_range(0, 9) < 7);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
